cbg_mem_responder: RTL and testbench

- Memory-side responder for the per-row LSU request interface of the PE array.
- Accepts read and write requests from NUM_PORTS LSU ports and arbitrates them round-robin onto one single-ported on-chip bank.
- Returns read data and write acknowledgements per port.
- Provides an init-triggered bank clear sequence, so the array can start from a known memory image.

---
 rtl/cbg_mem_responder.sv | 158 +++++++++++++++
 tb/tb_cbg_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbg_mem_responder.sv
// Memory-side responder for the per-row LSU ports: round-robin arbitration onto
// one single-ported bank, per-port read data / write ack, and an init-driven bank clear.
module cbg_mem_responder #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init,
  input  logic [NUM_PORTS-1:0]        r_req,
  input  logic [NUM_PORTS-1:0]        w_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS*DATA_W-1:0] rdata,
  output logic [NUM_PORTS-1:0]        r_valid,
  output logic [NUM_PORTS-1:0]        w_ack,
  output logic                        busy,
  output logic                        clr_done
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] r_valid_q, r_valid_d;
  logic [NUM_PORTS-1:0] w_ack_q, w_ack_d;
  logic [DATA_W-1:0]   rdata_q [NUM_PORTS];
  logic [DATA_W-1:0]   rdata_d [NUM_PORTS];
  logic                busy_q, busy_d;
  logic                clr_done_q, clr_done_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [ADDR_W-1:0]   addr_a  [NUM_PORTS];
  logic [DATA_W-1:0]   wdata_a [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign addr_a[g]                  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g]                 = wdata[g*DATA_W +: DATA_W];
    assign rdata[g*DATA_W +: DATA_W]  = rdata_q[g];
  end

  logic [NUM_PORTS-1:0] elig;
  logic                 found;
  logic [PW-1:0]        win, cand;
  logic [ADDR_W-1:0]    g_addr;
  int unsigned          g_addr_u;
  logic                 in_range;

  // A port is masked while its completion pulse is out, so a held request
  // is not granted twice.
  always_comb begin
    elig  = (r_req | w_req) & ~(r_valid_q | w_ack_q);
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((32'(ptr_q) + i) % NUM_PORTS);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    r_valid_d  = '0;
    w_ack_d    = '0;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    clr_done_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cnt_q;
    mem_wdata  = '0;
    g_addr     = addr_a[win];
    g_addr_u   = 32'(g_addr);
    in_range   = g_addr_u < DEPTH;

    case (state_q)
      SERVE: begin
        if (init) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (found) begin
          ptr_d = PW'((32'(win) + 1) % NUM_PORTS);
          // Writes take priority; a simultaneous read stays pending.
          if (w_req[win]) begin
            w_ack_d[win] = 1'b1;
            mem_we       = in_range;
            mem_waddr    = g_addr[AW-1:0];
            mem_wdata    = wdata_a[win];
          end else begin
            r_valid_d[win] = 1'b1;
            rdata_d[win]   = in_range ? mem[g_addr[AW-1:0]] : '0;
          end
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d    = SERVE;
          busy_d     = 1'b0;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SERVE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      r_valid_q  <= '0;
      w_ack_q    <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) rdata_q[p] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      r_valid_q  <= r_valid_d;
      w_ack_q    <= w_ack_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      rdata_q    <= rdata_d;
    end
  end

  // Bank contents survive reset; only the access itself is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign r_valid  = r_valid_q;
  assign w_ack    = w_ack_q;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_cbg_mem_responder.sv
// Scoreboard bench for cbg_mem_responder: drivers push expected completions,
// a negedge monitor pops and compares them per port.
module tb_cbg_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic [3:0]   r_req, w_req;
  logic [39:0]  addr;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic [3:0]   r_valid, w_ack;
  logic         busy, clr_done;

  logic         r_a [4];
  logic         w_a [4];
  logic [9:0]   addr_a [4];
  logic [31:0]  wdata_a [4];
  logic [31:0]  rd_a [4];

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign r_req[g]            = r_a[g];
    assign w_req[g]            = w_a[g];
    assign addr[g*10 +: 10]    = addr_a[g];
    assign wdata[g*32 +: 32]   = wdata_a[g];
    assign rd_a[g]             = rdata[g*32 +: 32];
  end

  cbg_mem_responder #(
    .NUM_PORTS(4),
    .ADDR_W   (10),
    .DATA_W   (32),
    .DEPTH    (1024)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
    .r_req   (r_req),
    .w_req   (w_req),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .r_valid (r_valid),
    .w_ack   (w_ack),
    .busy    (busy),
    .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {int port; bit is_wr; logic [31:0] data;} exp_t;
  typedef struct {int cyc; int port;} log_t;

  exp_t exp_q[$];
  log_t log_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   clr_cyc = -1;
  int   busy_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic sb_check(input int p, input bit is_wr, input logic [31:0] d);
    int idx;
    idx = -1;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].port == p) idx = i;
    log_q.push_back('{cyc, p});
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL sb_port%0d: got unexpected %s completion, expected none", p, is_wr ? "write" : "read");
    end else begin
      if (exp_q[idx].is_wr != is_wr || (!is_wr && exp_q[idx].data !== d)) begin
        errors++;
        $display("FAIL sb_port%0d: got %s data %0h, expected %s data %0h", p,
                 is_wr ? "write" : "read", d, exp_q[idx].is_wr ? "write" : "read", exp_q[idx].data);
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation of its port.
  initial begin
    forever begin
      @(negedge clk);
      if (clr_done) clr_cyc = cyc;
      for (int p = 0; p < 4; p++) begin
        if ((r_valid[2'(p)] || w_ack[2'(p)]) && busy) busy_pulses++;
        if (w_ack[2'(p)])   sb_check(p, 1'b1, 32'h0);
        if (r_valid[2'(p)]) sb_check(p, 1'b0, rd_a[2'(p)]);
      end
    end
  end

  task automatic txn(input int p, input bit rd, input bit wr, input logic [9:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, output int lat);
    logic [1:0] pi;
    int n;
    bit cw, cr;
    pi = 2'(p);
    if (wr) exp_q.push_back('{p, 1'b1, 32'h0});
    if (rd) exp_q.push_back('{p, 1'b0, exp_rd});
    addr_a[pi]  = a;
    wdata_a[pi] = d;
    r_a[pi]     = rd;
    w_a[pi]     = wr;
    n = 0; lat = 0; cw = 0; cr = 0;
    while ((r_a[pi] || w_a[pi]) && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (cw) w_a[pi] = 1'b0;
      if (cr) r_a[pi] = 1'b0;
      cw = 0; cr = 0;
      if (w_ack[pi])   begin cw = 1; if (lat == 0) lat = n; end
      if (r_valid[pi]) begin cr = 1; if (lat == 0) lat = n; end
    end
    if (r_a[pi] || w_a[pi]) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout_port%0d: got no completion after %0d cycles, expected one", p, n);
      r_a[pi] = 1'b0;
      w_a[pi] = 1'b0;
    end
  endtask

  task automatic port_pair(input int p);
    int l;
    txn(p, 1'b1, 1'b0, 10'd5, 32'h0, 32'hDEADBEEF, l);
    txn(p, 1'b1, 1'b0, 10'(100 + p), 32'h0, 32'h0, l);
  endtask

  task automatic run_clear();
    int n, clrs;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    n = 0; clrs = 0;
    while (busy && n < 2000) begin
      n++;
      @(posedge clk); #1;
      if (clr_done) clrs++;
    end
    chk("clr_busy_cycles", 64'(n), 64'd1024);
    chk("clr_done_at_end", 64'(clr_done), 64'd1);
    @(posedge clk); #1;
    if (clr_done) clrs++;
    chk("clr_done_count", 64'(clrs), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    init = 1'b0;
    for (int p = 0; p < 4; p++) begin
      r_a[p] = 1'b0; w_a[p] = 1'b0; addr_a[p] = '0; wdata_a[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_clr_done", 64'(clr_done), 64'd0);
    chk("rst_r_valid",  64'(r_valid),  64'd0);
    chk("rst_w_ack",    64'(w_ack),    64'd0);
    chk("rst_rdata_lo", rdata[63:0],   64'd0);
    chk("rst_rdata_hi", rdata[127:64], 64'd0);

    // Clear, then the top word reads as zero one cycle after grant
    run_clear();
    txn(2, 1'b1, 1'b0, 10'h3FF, 32'h0, 32'h0, lat);
    chk("t1_read_latency", 64'(lat), 64'd1);

    // Write then read-after-write from another port
    txn(0, 1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 32'h0, lat);
    chk("t2_write_latency", 64'(lat), 64'd1);
    txn(1, 1'b1, 1'b0, 10'd5, 32'h0, 32'hDEADBEEF, lat);
    chk("t2_read_latency", 64'(lat), 64'd1);

    // All four ports at once from ptr=0, then immediately again
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    log_q.delete();
    fork
      port_pair(0);
      port_pair(1);
      port_pair(2);
      port_pair(3);
    join
    chk("t3_completions", 64'(log_q.size()), 64'd8);
    for (int i = 1; i < log_q.size(); i++) begin
      chk($sformatf("t3_order_%0d", i), 64'(log_q[i].port), 64'(i % 4));
      chk($sformatf("t3_cycle_%0d", i), 64'(log_q[i].cyc - log_q[0].cyc), 64'(i));
    end
    if (log_q.size() > 0) chk("t3_order_0", 64'(log_q[0].port), 64'd0);

    // Read and write together: write first, read returns the new value
    txn(3, 1'b1, 1'b1, 10'd7, 32'h12345678, 32'h12345678, lat);

    // Read pending across a clear returns zero right after clr_done
    txn(1, 1'b0, 1'b1, 10'd50, 32'hA5A5A5A5, 32'h0, lat);
    log_q.delete();
    fork
      txn(1, 1'b1, 1'b0, 10'd50, 32'h0, 32'h0, lat);
      run_clear();
    join
    chk("t5_completions", 64'(log_q.size()), 64'd1);
    if (log_q.size() > 0) begin
      chk("t5_port", 64'(log_q[0].port), 64'd1);
      chk("t5_after_clr", 64'(log_q[0].cyc - clr_cyc), 64'd1);
    end

    // Reset in the middle of a clear
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_clr_done", 64'(clr_done), 64'd0);
    @(posedge clk); #1;
    chk("t6_serve_busy", 64'(busy), 64'd0);
    txn(2, 1'b0, 1'b1, 10'd20, 32'hCAFEF00D, 32'h0, lat);
    chk("t6_write_latency", 64'(lat), 64'd1);
    txn(0, 1'b1, 1'b0, 10'd20, 32'h0, 32'hCAFEF00D, lat);
    chk("t6_read_latency", 64'(lat), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("pulses_while_busy", 64'(busy_pulses), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
